// File: rtl/pwm_processeur_cpu_debug_ocimem.sv
// Debug on-chip memory: 256x32 RAM shared by JTAG debug commands (MonAReg/MonDReg) and an Avalon slave.
// Latency: JTAG read loads MonDReg 2 cycles after the strobe; Avalon read acks in cycle 2, write in cycle 1.
// Backpressure: waitrequest high except the ack cycle; JTAG strobes arriving while busy are held one deep.
// Option: PWM_PROCESSEUR_CPU_OCIMEM_PARITY_EN adds an even-parity bit per word and a sticky parity_error output.
module pwm_processeur_cpu_debug_ocimem (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        take_no_action_ocimem_a,
    input  logic [7:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    input  logic        debugaccess,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic [31:0] MonDReg,
`ifdef PWM_PROCESSEUR_CPU_OCIMEM_PARITY_EN
    output logic        parity_error,
`endif
    output logic        jtag_pending
);

`ifdef PWM_PROCESSEUR_CPU_OCIMEM_PARITY_EN
    localparam int RAM_W = 33;
`else
    localparam int RAM_W = 32;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_JTAG_RD, S_JTAG_RD_DATA, S_JTAG_WR, S_AV_RD, S_AV_RD_DATA, S_AV_WR
    } state_e;

    typedef enum logic [1:0] {CMD_NONE, CMD_A, CMD_NA, CMD_B} cmd_e;

    state_e       state_q, state_d;
    logic [7:0]   mon_a_q, mon_a_d;
    logic [31:0]  mon_d_q, mon_d_d;
    cmd_e         pend_cmd_q, pend_cmd_d;
    logic [36:3]  pend_jdo_q, pend_jdo_d;
    logic [7:0]   av_addr_q, av_addr_d;
    logic [31:0]  av_wdata_q, av_wdata_d;
    logic [3:0]   av_be_q, av_be_d;
    logic         av_dbg_q, av_dbg_d;
    logic [31:0]  rd_hold_q, rd_hold_d;

    cmd_e         new_cmd, cur_cmd;
    logic [36:3]  cur_jdo;
    logic         jtag_go;
    logic         pend_op;

    logic             ram_rd_en, ram_we;
    logic [7:0]       ram_raddr, ram_waddr;
    logic [31:0]      ram_wdata;
    logic [3:0]       ram_be;
    logic [RAM_W-1:0] mem [256];
    logic [RAM_W-1:0] ram_rdata_q;
    logic             unused_bits;

`ifdef PWM_PROCESSEUR_CPU_OCIMEM_PARITY_EN
    logic         par_err_q, par_err_d;
    logic [31:0]  ram_merged;
    assign unused_bits  = ^{jdo[37], jdo[2:0]};
    assign parity_error = par_err_q;
`else
    assign unused_bits  = ^{jdo[37], jdo[2:0], cur_jdo[36]};
`endif

    // Strobe priority; a fresh strobe supersedes a held one that has not started.
    always_comb begin
        new_cmd = CMD_NONE;
        if (take_action_ocimem_a)         new_cmd = CMD_A;
        else if (take_no_action_ocimem_a) new_cmd = CMD_NA;
        else if (take_action_ocimem_b)    new_cmd = CMD_B;
        cur_cmd = (new_cmd != CMD_NONE) ? new_cmd : pend_cmd_q;
        cur_jdo = (new_cmd != CMD_NONE) ? jdo[36:3] : pend_jdo_q;
        jtag_go = (cur_cmd == CMD_NA) || (cur_cmd == CMD_B) || ((cur_cmd == CMD_A) && cur_jdo[35]);
        pend_op = (pend_cmd_q == CMD_NA) || (pend_cmd_q == CMD_B) ||
                  ((pend_cmd_q == CMD_A) && pend_jdo_q[35]);
    end

    // Next-state, debug register updates and RAM port control.
    always_comb begin
        state_d    = state_q;
        mon_a_d    = mon_a_q;
        mon_d_d    = mon_d_q;
        pend_cmd_d = pend_cmd_q;
        pend_jdo_d = pend_jdo_q;
        av_addr_d  = av_addr_q;
        av_wdata_d = av_wdata_q;
        av_be_d    = av_be_q;
        av_dbg_d   = av_dbg_q;
        rd_hold_d  = rd_hold_q;
        ram_rd_en  = 1'b0;
        ram_raddr  = mon_a_q;
        ram_we     = 1'b0;
        ram_waddr  = mon_a_q;
        ram_wdata  = mon_d_q;
        ram_be     = 4'hF;
`ifdef PWM_PROCESSEUR_CPU_OCIMEM_PARITY_EN
        par_err_d  = par_err_q;
`endif
        // Strobes during a busy op wait here until the FSM is back in IDLE.
        if (state_q != S_IDLE && new_cmd != CMD_NONE) begin
            pend_cmd_d = new_cmd;
            pend_jdo_d = jdo[36:3];
        end
        unique case (state_q)
            S_IDLE: begin
                pend_cmd_d = CMD_NONE;
                case (cur_cmd)
                    CMD_A: begin
                        mon_a_d = cur_jdo[24:17];
`ifdef PWM_PROCESSEUR_CPU_OCIMEM_PARITY_EN
                        if (cur_jdo[36]) par_err_d = 1'b0;
`endif
                    end
                    CMD_NA:  mon_a_d = mon_a_q + 8'd1;
                    CMD_B:   mon_d_d = cur_jdo[34:3];
                    default: ;
                endcase
                if (jtag_go) begin
                    state_d = (cur_cmd == CMD_B) ? S_JTAG_WR : S_JTAG_RD;
                end else if (read) begin
                    state_d   = S_AV_RD;
                    av_addr_d = address;
                end else if (write) begin
                    state_d    = S_AV_WR;
                    av_addr_d  = address;
                    av_wdata_d = writedata;
                    av_be_d    = byteenable;
                    av_dbg_d   = debugaccess;
                end
            end
            S_JTAG_RD: begin
                ram_rd_en = 1'b1;
                state_d   = S_JTAG_RD_DATA;
            end
            S_JTAG_RD_DATA: begin
                mon_d_d = ram_rdata_q[31:0];
`ifdef PWM_PROCESSEUR_CPU_OCIMEM_PARITY_EN
                if (^ram_rdata_q) par_err_d = 1'b1;
`endif
                state_d = S_IDLE;
            end
            S_JTAG_WR: begin
                ram_we  = 1'b1;
                mon_a_d = mon_a_q + 8'd1;
                state_d = S_IDLE;
            end
            S_AV_RD: begin
                ram_rd_en = 1'b1;
                ram_raddr = av_addr_q;
                state_d   = S_AV_RD_DATA;
            end
            S_AV_RD_DATA: begin
                rd_hold_d = ram_rdata_q[31:0];
`ifdef PWM_PROCESSEUR_CPU_OCIMEM_PARITY_EN
                if (^ram_rdata_q) par_err_d = 1'b1;
`endif
                state_d = S_IDLE;
            end
            S_AV_WR: begin
                ram_we    = av_dbg_q;
                ram_waddr = av_addr_q;
                ram_wdata = av_wdata_q;
                ram_be    = av_be_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef PWM_PROCESSEUR_CPU_OCIMEM_PARITY_EN
    // Parity covers the whole word, so partial writes merge with the stored bytes first.
    always_comb begin
        ram_merged = mem[ram_waddr][31:0];
        for (int b = 0; b < 4; b++) begin
            if (ram_be[b]) ram_merged[8*b +: 8] = ram_wdata[8*b +: 8];
        end
    end
`endif

    // RAM: registered read, byte-enabled write suppressed in any reset cycle; contents never reset.
    always_ff @(posedge clk) begin
        if (ram_rd_en) ram_rdata_q <= mem[ram_raddr];
        if (ram_we && reset_n) begin
`ifdef PWM_PROCESSEUR_CPU_OCIMEM_PARITY_EN
            mem[ram_waddr] <= {^ram_merged, ram_merged};
`else
            for (int b = 0; b < 4; b++) begin
                if (ram_be[b]) mem[ram_waddr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
`endif
        end
    end

    // Control and debug register state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            mon_a_q    <= '0;
            mon_d_q    <= '0;
            pend_cmd_q <= CMD_NONE;
            pend_jdo_q <= '0;
            av_addr_q  <= '0;
            av_wdata_q <= '0;
            av_be_q    <= '0;
            av_dbg_q   <= 1'b0;
            rd_hold_q  <= '0;
`ifdef PWM_PROCESSEUR_CPU_OCIMEM_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mon_a_q    <= mon_a_d;
            mon_d_q    <= mon_d_d;
            pend_cmd_q <= pend_cmd_d;
            pend_jdo_q <= pend_jdo_d;
            av_addr_q  <= av_addr_d;
            av_wdata_q <= av_wdata_d;
            av_be_q    <= av_be_d;
            av_dbg_q   <= av_dbg_d;
            rd_hold_q  <= rd_hold_d;
`ifdef PWM_PROCESSEUR_CPU_OCIMEM_PARITY_EN
            par_err_q  <= par_err_d;
`endif
        end
    end

    assign MonDReg      = mon_d_q;
    assign waitrequest  = !((state_q == S_AV_RD_DATA) || (state_q == S_AV_WR));
    assign readdata     = (state_q == S_AV_RD_DATA) ? ram_rdata_q[31:0] : rd_hold_q;
    assign jtag_pending = pend_op || (state_q == S_JTAG_RD) || (state_q == S_JTAG_RD_DATA) ||
                          (state_q == S_JTAG_WR);

endmodule
